conversor_bcd_display: RTL



---
 rtl/conversor_bcd_display_pkg.sv | 25 ++
 rtl/conversor_bcd_display_ajuste_bcd_nibble.sv | 19 +
 rtl/conversor_bcd_display.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/conversor_bcd_display_pkg.sv
// Shared definitions for the binary-to-BCD converter and the 7-segment decoders it feeds.
// Display codes: 0..15 render as hex digits, any code of 16 or above renders as "-".
package conversor_bcd_display_pkg;

    localparam int LARGURA_CODIGO = 7;
    localparam int LARGURA_VALOR  = 10;
    localparam int LARGURA_BCD    = 16;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARREGA = 2'd1,
        DESLOCA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam logic [LARGURA_CODIGO-1:0] CODIGO_ZERO         = 7'h00;
    localparam logic [LARGURA_CODIGO-1:0] CODIGO_HEX_MAX      = 7'h0F;
    localparam logic [LARGURA_CODIGO-1:0] CODIGO_TRACO        = 7'h10;
    localparam logic [LARGURA_CODIGO-1:0] CODIGO_MENOS_PADRAO = CODIGO_TRACO;

    function automatic logic [LARGURA_CODIGO-1:0] nibble_para_codigo(input logic [3:0] i_nibble);
        return {3'b000, i_nibble};
    endfunction

endpackage

// File: rtl/conversor_bcd_display_ajuste_bcd_nibble.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added before the shift,
// so that the following doubling carries correctly into the next decimal digit.
module ajuste_bcd_nibble
    import conversor_bcd_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    // Add-3 correction for nibbles >= 5
    always_comb begin
        if (i_nibble >= 4'd5) begin
            o_nibble = i_nibble + 4'd3;
        end else begin
            o_nibble = i_nibble;
        end
    end

endmodule

// File: rtl/conversor_bcd_display.sv
// Sequential 10-bit binary to BCD converter (one bit per clock) driving four 7-bit
// display codes; results update atomically at the end of each conversion.
module conversor_bcd_display
    import conversor_bcd_display_pkg::*;
#(
    parameter bit                        COM_SINAL    = 1'b1,
    parameter logic [LARGURA_CODIGO-1:0] CODIGO_MENOS = CODIGO_MENOS_PADRAO
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_inicio,
    input  logic [LARGURA_VALOR-1:0]  i_valor,
    output logic [LARGURA_CODIGO-1:0] o_digito0,
    output logic [LARGURA_CODIGO-1:0] o_digito1,
    output logic [LARGURA_CODIGO-1:0] o_digito2,
    output logic [LARGURA_CODIGO-1:0] o_digito3,
    output logic                      o_ocupado,
    output logic                      o_pronto
);

    estado_t                   r_estado;
    estado_t                   w_estado_prox;
    logic [LARGURA_VALOR-1:0]  r_valor;
    logic [LARGURA_VALOR-1:0]  r_mag;
    logic [LARGURA_BCD-1:0]    r_bcd;
    logic [3:0]                r_cont;
    logic                      r_sinal;
    logic [LARGURA_CODIGO-1:0] r_digito0;
    logic [LARGURA_CODIGO-1:0] r_digito1;
    logic [LARGURA_CODIGO-1:0] r_digito2;
    logic [LARGURA_CODIGO-1:0] r_digito3;
    logic                      r_ocupado;
    logic                      r_pronto;

    logic [LARGURA_BCD-1:0]    w_bcd_ajustado;
    logic [LARGURA_VALOR-1:0]  w_mag_entrada;
    logic                      w_sinal_entrada;

    for (genvar g = 0; g < 4; g++) begin : g_ajuste
        ajuste_bcd_nibble u_ajuste (
            .i_nibble (r_bcd[4*g +: 4]),
            .o_nibble (w_bcd_ajustado[4*g +: 4])
        );
    end

    // Magnitude and sign of the captured value; -512 maps to 512 without overflow
    always_comb begin
        w_sinal_entrada = 1'b0;
        w_mag_entrada   = r_valor;
        if (COM_SINAL && r_valor[LARGURA_VALOR-1]) begin
            w_sinal_entrada = 1'b1;
            w_mag_entrada   = ~r_valor + 10'd1;
        end else begin
            w_sinal_entrada = 1'b0;
            w_mag_entrada   = r_valor;
        end
    end

    // Next-state logic for the conversion sequencer
    always_comb begin
        w_estado_prox = r_estado;
        case (r_estado)
            OCIOSO: begin
                if (i_inicio) begin
                    w_estado_prox = CARREGA;
                end else begin
                    w_estado_prox = OCIOSO;
                end
            end
            CARREGA: w_estado_prox = DESLOCA;
            DESLOCA: begin
                if (r_cont == 4'd0) begin
                    w_estado_prox = FIM;
                end else begin
                    w_estado_prox = DESLOCA;
                end
            end
            FIM:     w_estado_prox = OCIOSO;
            default: w_estado_prox = OCIOSO;
        endcase
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    // Datapath: capture, shift-add-3 iterations and atomic output update
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valor   <= 10'd0;
            r_mag     <= 10'd0;
            r_bcd     <= 16'd0;
            r_cont    <= 4'd0;
            r_sinal   <= 1'b0;
            r_digito0 <= CODIGO_ZERO;
            r_digito1 <= CODIGO_ZERO;
            r_digito2 <= CODIGO_ZERO;
            r_digito3 <= CODIGO_ZERO;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (i_inicio) begin
                        r_valor   <= i_valor;
                        r_ocupado <= 1'b1;
                    end
                end
                CARREGA: begin
                    r_mag   <= w_mag_entrada;
                    r_sinal <= w_sinal_entrada;
                    r_bcd   <= 16'd0;
                    r_cont  <= 4'd9;
                end
                DESLOCA: begin
                    {r_bcd, r_mag} <= {w_bcd_ajustado, r_mag} << 1;
                    r_cont         <= r_cont - 4'd1;
                end
                FIM: begin
                    r_digito0 <= nibble_para_codigo(r_bcd[3:0]);
                    r_digito1 <= nibble_para_codigo(r_bcd[7:4]);
                    r_digito2 <= nibble_para_codigo(r_bcd[11:8]);
                    if (COM_SINAL) begin
                        r_digito3 <= r_sinal ? CODIGO_MENOS : CODIGO_ZERO;
                    end else begin
                        r_digito3 <= nibble_para_codigo(r_bcd[15:12]);
                    end
                    r_pronto  <= 1'b1;
                    r_ocupado <= 1'b0;
                end
                default: r_ocupado <= 1'b0;
            endcase
        end
    end

    assign o_digito0 = r_digito0;
    assign o_digito1 = r_digito1;
    assign o_digito2 = r_digito2;
    assign o_digito3 = r_digito3;
    assign o_ocupado = r_ocupado;
    assign o_pronto  = r_pronto;

endmodule
